// File: rtl/ntt_poly_loader.sv
// ntt_poly_loader
// ---------------
// Streaming front end for the NTT pointwise-multiplication stage. Coefficients
// arrive one per beat on a valid/ready stream. The first N accepted beats fill
// polynomial A and the next N fill polynomial B. Each coefficient is reduced
// into [0, Q) on entry, so the multiplier downstream only ever sees canonical
// operands.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset (clears the arrays too)
//   start      - begin a new load; only honoured in IDLE or DONE
//   in_valid   - in_data carries a coefficient
//   in_ready   - loader accepts a coefficient this cycle (registered)
//   in_data    - unsigned coefficient
//   poly_a     - polynomial A coefficients, [N-1:0] x WIDTH, straight from flops
//   poly_b     - polynomial B coefficients, [N-1:0] x WIDTH, straight from flops
//   poly_valid - both arrays complete and stable
//   done       - one-cycle pulse in the cycle after the last B beat
//   busy       - high while loading A or B
//   range_err  - sticky: a coefficient >= 2Q was seen in the current load
module ntt_poly_loader #(
    parameter int N     = 256,
    parameter int WIDTH = 32,
    parameter int Q     = 3329
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic [N-1:0][WIDTH-1:0]   poly_a,
    output logic [N-1:0][WIDTH-1:0]   poly_b,
    output logic                      poly_valid,
    output logic                      done,
    output logic                      busy,
    output logic                      range_err
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] Q_W    = WIDTH'(Q);
    localparam logic [WIDTH-1:0] Q2_W   = WIDTH'(2 * Q);
    localparam logic [IDX_W-1:0] LAST_W = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_A = 2'd1,
        S_LOAD_B = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Reduce one coefficient: returns {out_of_range, canonical value}.
    // Values >= 2Q are not representable after one subtraction, so they
    // are replaced by zero and flagged.
    function automatic logic [WIDTH:0] reduce_coeff(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] r;
        if (d < Q_W) begin
            r = {1'b0, d};
        end else if (d < Q2_W) begin
            r = {1'b0, d - Q_W};
        end else begin
            r = {1'b1, {WIDTH{1'b0}}};
        end
        return r;
    endfunction

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N-1:0][WIDTH-1:0]   poly_a_q, poly_a_d;
    logic [N-1:0][WIDTH-1:0]   poly_b_q, poly_b_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;
    logic                      poly_valid_q, poly_valid_d;
    logic                      done_q, done_d;
    logic                      range_err_q, range_err_d;

    logic                      beat_s;
    logic                      last_beat_s;
    logic                      over_s;
    logic [WIDTH-1:0]          red_s;

    // Next-state, array write and flag computation.
    always_comb begin
        beat_s          = in_valid && in_ready_q;
        last_beat_s     = (idx_q == LAST_W);
        {over_s, red_s} = reduce_coeff(in_data);

        state_d     = state_q;
        idx_d       = idx_q;
        poly_a_d    = poly_a_q;
        poly_b_d    = poly_b_q;
        range_err_d = range_err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD_A;
                    idx_d       = {IDX_W{1'b0}};
                    range_err_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD_A: begin
                // start is deliberately ignored while loading
                if (beat_s) begin
                    poly_a_d[idx_q] = red_s;
                    range_err_d     = range_err_q | over_s;
                    if (last_beat_s) begin
                        state_d = S_LOAD_B;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_LOAD_B: begin
                if (beat_s) begin
                    poly_b_d[idx_q] = red_s;
                    range_err_d     = range_err_q | over_s;
                    if (last_beat_s) begin
                        state_d = S_DONE;
                        idx_d   = {IDX_W{1'b0}};
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so that the
        // registered versions line up with the state flop.
        in_ready_d   = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        busy_d       = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        poly_valid_d = (state_d == S_DONE);
    end

    // State, arrays and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= {IDX_W{1'b0}};
            poly_a_q     <= '0;
            poly_b_q     <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            poly_valid_q <= 1'b0;
            done_q       <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            poly_a_q     <= poly_a_d;
            poly_b_q     <= poly_b_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            poly_valid_q <= poly_valid_d;
            done_q       <= done_d;
            range_err_q  <= range_err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign poly_valid = poly_valid_q;
    assign done       = done_q;
    assign range_err  = range_err_q;
    assign poly_a     = poly_a_q;
    assign poly_b     = poly_b_q;

endmodule

// File: tb/tb_ntt_poly_loader.sv
// Testbench for ntt_poly_loader (N=4, WIDTH=32, Q=3329). Directed steps for
// each test-plan item followed by a randomized stream, all checked every
// cycle against a transaction-level model: a count of accepted beats, a
// loading/complete flag and two plain coefficient arrays.
module tb_ntt_poly_loader;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int Q     = 3329;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [N-1:0][WIDTH-1:0]  poly_a;
    logic [N-1:0][WIDTH-1:0]  poly_b;
    logic                     poly_valid;
    logic                     done;
    logic                     busy;
    logic                     range_err;

    int checks   = 0;
    int failures = 0;

    // reference model
    longint m_a [N];
    longint m_b [N];
    int     m_cnt;
    bit     m_loading;
    bit     m_complete;
    bit     m_done;
    bit     m_err;

    ntt_poly_loader #(.N(N), .WIDTH(WIDTH), .Q(Q)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .poly_a     (poly_a),
        .poly_b     (poly_b),
        .poly_valid (poly_valid),
        .done       (done),
        .busy       (busy),
        .range_err  (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint reduce(input longint d);
        if (d < Q) return d;
        else if (d < 2 * Q) return d - Q;
        else return 0;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_a[i] = 0;
            m_b[i] = 0;
        end
        m_cnt      = 0;
        m_loading  = 1'b0;
        m_complete = 1'b0;
        m_done     = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic check_all();
        chk("in_ready",   longint'(in_ready),   longint'(m_loading));
        chk("busy",       longint'(busy),       longint'(m_loading));
        chk("poly_valid", longint'(poly_valid), longint'(m_complete));
        chk("done",       longint'(done),       longint'(m_done));
        chk("range_err",  longint'(range_err),  longint'(m_err));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("poly_a[%0d]", i), longint'(poly_a[i]), m_a[i]);
            chk($sformatf("poly_b[%0d]", i), longint'(poly_b[i]), m_b[i]);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check.
    task automatic step(input logic s, input logic v, input logic [WIDTH-1:0] d,
                        input logic r);
        rst      = r;
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        m_done = 1'b0;
        if (r) begin
            model_reset();
        end else if (m_loading) begin
            if (v) begin
                if (m_cnt < N) m_a[m_cnt] = reduce(longint'(d));
                else           m_b[m_cnt - N] = reduce(longint'(d));
                if (longint'(d) >= 2 * Q) m_err = 1'b1;
                m_cnt++;
                if (m_cnt == 2 * N) begin
                    m_loading  = 1'b0;
                    m_complete = 1'b1;
                    m_done     = 1'b1;
                end
            end
        end else if (s) begin
            m_loading  = 1'b1;
            m_complete = 1'b0;
            m_cnt      = 0;
            m_err      = 1'b0;
        end
        #1;
        check_all();
    endtask

    function automatic logic [WIDTH-1:0] rand_coeff();
        case ($urandom_range(0, 3))
            0:       return WIDTH'($urandom_range(0, Q - 1));
            1:       return WIDTH'($urandom_range(Q, 2 * Q - 1));
            2:       return WIDTH'($urandom_range(2 * Q, 2 * Q + 100));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();

        // reset state
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("reset_in_ready", longint'(in_ready), 0);

        // beats offered in IDLE are ignored
        step(1'b0, 1'b1, 32'd99, 1'b0);
        step(1'b0, 1'b1, 32'd77, 1'b0);

        // 1. basic load
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 1; k <= 2 * N; k++) step(1'b0, 1'b1, WIDTH'(k), 1'b0);
        chk("t1_done_after_8", longint'(done), 1);
        chk("t1_a0", longint'(poly_a[0]), 1);
        chk("t1_b3", longint'(poly_b[3]), 8);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("t1_valid_holds", longint'(poly_valid), 1);

        // 2. reduction
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd3328, 1'b0);
        step(1'b0, 1'b1, 32'd3329, 1'b0);
        step(1'b0, 1'b1, 32'd6657, 1'b0);
        step(1'b0, 1'b1, 32'd6658, 1'b0);
        chk("t2_err_set", longint'(range_err), 1);
        chk("t2_a2", longint'(poly_a[2]), 3328);
        for (int k = 0; k < N; k++) step(1'b0, 1'b1, WIDTH'(20 + k), 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("t2_err_sticky", longint'(range_err), 1);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t2_err_cleared", longint'(range_err), 0);

        // 3. backpressure and gaps: valid pattern 1,0,0 across 8 beats
        for (int k = 0; k < 2 * N; k++) begin
            step(1'b0, 1'b1, WIDTH'(100 + k), 1'b0);
            step(1'b0, 1'b0, WIDTH'(555), 1'b0);
            step(1'b0, 1'b0, WIDTH'(666), 1'b0);
        end
        chk("t3_b0", longint'(poly_b[0]), 104);
        step(1'b0, 1'b1, 32'd999, 1'b0);
        step(1'b0, 1'b1, 32'd998, 1'b0);
        chk("t3_ready_done", longint'(in_ready), 0);

        // 4. start while busy
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, WIDTH'(200 + k), 1'b0);
        step(1'b1, 1'b1, 32'd203, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 4; k < 2 * N; k++) step(1'b0, 1'b1, WIDTH'(200 + k), 1'b0);
        chk("t4_done", longint'(done), 1);
        chk("t4_a3", longint'(poly_a[3]), 203);

        // 5. reset mid-load
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < N + 2; k++) step(1'b0, 1'b1, WIDTH'(300 + k), 1'b0);
        step(1'b0, 1'b1, 32'd399, 1'b1);
        chk("t5_a0_zero", longint'(poly_a[0]), 0);
        chk("t5_ready", longint'(in_ready), 0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 2 * N; k++) step(1'b0, 1'b1, rand_coeff(), 1'b0);

        // 6. back-to-back: start in the done cycle
        chk("t6_done_pre", longint'(done), 1);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        chk("t6_valid_drop", longint'(poly_valid), 0);
        for (int k = 10; k <= 17; k++) step(1'b0, 1'b1, WIDTH'(k), 1'b0);
        chk("t6_done", longint'(done), 1);
        chk("t6_mult0", (longint'(poly_a[0]) * longint'(poly_b[0])) % Q, 140);
        for (int i = 0; i < N; i++)
            chk($sformatf("t6_mult%0d", i),
                (longint'(poly_a[i]) * longint'(poly_b[i])) % Q,
                (m_a[i] * m_b[i]) % Q);

        // start coincident with the final B beat is ignored
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 2 * N - 1; k++) step(1'b0, 1'b1, rand_coeff(), 1'b0);
        step(1'b1, 1'b1, rand_coeff(), 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);

        // randomized stream
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0),
                 rand_coeff(),
                 ($urandom_range(0, 149) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_poly_loader.md
# ntt_poly_loader

Streaming front end for the NTT pointwise-multiplication stage. It accepts coefficients one per beat over a valid/ready stream, loads polynomial A and then polynomial B into parallel register arrays, and presents both as full N-wide arrays to the pointwise multiplier. Each coefficient is range-checked and reduced into [0, Q) on entry, so the multiplier always sees canonical NTT-domain operands.

## Interface
Parameters:
- N, 256: coefficients per polynomial; must be ≥ 2.
- WIDTH, 32: coefficient bit width; must satisfy 2·Q < 2^WIDTH.
- Q, 3329: modulus.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a new load; honoured only in IDLE or DONE.
- in_valid  input  1  in_data carries a coefficient.
- in_ready  output  1  loader accepts a coefficient this cycle.
- in_data  input  WIDTH  coefficient value, unsigned.
- poly_a  output  WIDTH × N  array of polynomial A coefficients, indexed [N-1:0].
- poly_b  output  WIDTH × N  array of polynomial B coefficients, indexed [N-1:0].
- poly_valid  output  1  both arrays are complete and stable.
- done  output  1  one-cycle pulse when a load completes.
- busy  output  1  high in LOAD_A and LOAD_B.
- range_err  output  1  sticky flag: at least one coefficient ≥ 2Q was received in the current load.

## Operation
- States: IDLE, LOAD_A, LOAD_B, DONE.
  - IDLE → LOAD_A on start.
  - LOAD_A → LOAD_B after the N-th accepted beat.
  - LOAD_B → DONE after the N-th accepted beat.
  - DONE → LOAD_A on start; otherwise DONE holds indefinitely.
- Index counter idx is $clog2(N) bits wide. It is cleared on start and on the LOAD_A→LOAD_B transition, and increments on each accepted beat (in_valid && in_ready).
- Beat k of LOAD_A writes poly_a[k]. Beat k of LOAD_B writes poly_b[k]. Ascending index order only.
- Reduction of each accepted value d:
  - d < Q: store d.
  - Q ≤ d < 2Q: store d − Q.
  - d ≥ 2Q: store 0 and set range_err.
- range_err is cleared on start and on rst. It is sticky through DONE.
- start while busy is ignored: no restart, no counter clear.
- start in the same cycle as the final LOAD_B beat is ignored. The block enters DONE.
- A new load does not clear the arrays. Entries are overwritten as beats arrive.
- poly_valid is low from the accepting start edge until the next DONE. Consumers must not sample the arrays while poly_valid is low.

## Timing
- Reset values: state = IDLE, idx = 0, every poly_a/poly_b entry = 0, in_ready = 0, poly_valid = 0, done = 0, busy = 0, range_err = 0.
- rst takes priority over all other inputs. rst mid-load aborts the load and restores all reset values, including the arrays.
- in_ready is high exactly when the state is LOAD_A or LOAD_B. It is registered from state, with no combinational path from in_valid.
- Beats:
  - A beat writes its array entry at the accepting edge.
  - Throughput is one coefficient per cycle while in_valid is held high.
  - Gaps in in_valid are allowed; idx holds during them.
- The first beat can be accepted in the cycle after start is sampled.
- LOAD_A → LOAD_B takes no extra cycle. The cycle after the N-th A beat can accept B[0].
- Completion cycle: at the edge that accepts B[N-1], the state becomes DONE. In the following cycle:
  - done = 1 for exactly one cycle;
  - poly_valid = 1;
  - busy = 0;
  - in_ready = 0.
- Minimum load time is 2N + 1 cycles from start to done.
- The arrays are driven directly from flops with no combinational logic after the registers.
- The downstream multiplier is combinational, so its products are valid whenever poly_valid = 1.

## Test plan
Use N = 4, Q = 3329, WIDTH = 32 unless stated otherwise.

1. Basic load. start, then 8 back-to-back beats: 1, 2, 3, 4, 5, 6, 7, 8.
   - poly_a = {1, 2, 3, 4} and poly_b = {5, 6, 7, 8}, by index 0..3.
   - done pulses once, 9 cycles after the start edge.
   - poly_valid stays high afterwards.
   - range_err = 0.
2. Reduction. A beats: 3328, 3329, 6657, 6658.
   - poly_a = {3328, 0, 3328, 0}.
   - range_err = 1 after the fourth beat and stays 1 through DONE.
   - Next start clears range_err.
3. Backpressure and gaps. in_valid toggles 1, 0, 0, 1, … across 8 beats.
   - Arrays match the beat order.
   - idx never advances on idle cycles.
   - in_ready is 0 in IDLE and DONE.
   - Beats offered in IDLE are ignored; the arrays are unchanged.
4. start while busy. Assert start after 3 A beats, then continue streaming.
   - The load is not restarted.
   - done fires after the 8th accepted beat.
   - Array contents are correct.
5. Reset mid-load. Assert rst after 2 B beats.
   - Next cycle: all arrays 0, poly_valid = 0, in_ready = 0, state IDLE.
   - A fresh start then loads correctly.
6. Back-to-back loads. After DONE, start immediately and stream new values 10..17.
   - poly_valid drops at the accepting edge.
   - done pulses again after 8 beats.
   - Arrays equal {10, 11, 12, 13} and {14, 15, 16, 17}.
   - The connected ntt_pointwise_mult output equals A[i]·B[i] mod Q, e.g. 10·14 = 140.
